// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the parametrised JTAG TAP controller.
package jtag_tap_pkg;

  localparam int unsigned IDCODE_WIDTH = 32;
  localparam logic [31:0] OP_IDCODE    = 32'd1;
  localparam logic [31:0] OP_USER_BASE = 32'd2;

  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  // All-ones opcode for an IR of width w (w <= 32).
  function automatic logic [31:0] op_bypass(int unsigned w);
    logic [63:0] v;
    v = (64'd1 << w) - 64'd1;
    return v[31:0];
  endfunction

  function automatic logic [31:0] op_user(int unsigned i);
    return OP_USER_BASE + i;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register, next-state logic and
// decoded capture/shift/update strobes for the IR and DR paths.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       clk,
  input  logic       reset_b,
  input  logic       i_tms,
  output tap_state_e o_state,
  output logic       o_next_tlr,
  output logic       o_cap_dr,
  output logic       o_shift_dr,
  output logic       o_upd_dr,
  output logic       o_cap_ir,
  output logic       o_shift_ir,
  output logic       o_upd_ir
);

  tap_state_e r_state;
  tap_state_e w_next;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) r_state <= TLR;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      TLR:      w_next = i_tms ? TLR      : RTI;
      RTI:      w_next = i_tms ? SEL_DR   : RTI;
      SEL_DR:   w_next = i_tms ? SEL_IR   : CAP_DR;
      CAP_DR:   w_next = i_tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: w_next = i_tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: w_next = i_tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: w_next = i_tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: w_next = i_tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   w_next = i_tms ? SEL_DR   : RTI;
      SEL_IR:   w_next = i_tms ? TLR      : CAP_IR;
      CAP_IR:   w_next = i_tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: w_next = i_tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: w_next = i_tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: w_next = i_tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: w_next = i_tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   w_next = i_tms ? SEL_DR   : RTI;
      default:  w_next = TLR;
    endcase
  end

  always_comb begin
    o_state    = r_state;
    o_next_tlr = (w_next == TLR);
    o_cap_dr   = (r_state == CAP_DR);
    o_shift_dr = (r_state == SHIFT_DR);
    o_upd_dr   = (r_state == UPD_DR);
    o_cap_ir   = (r_state == CAP_IR);
    o_shift_ir = (r_state == SHIFT_IR);
    o_upd_ir   = (r_state == UPD_IR);
  end

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised TAP: IR, BYPASS/IDCODE/user DRs, DR select mux and the
// falling-edge TDO stage. The state machine lives in jtag_tap_fsm.
module jtag_tap_param
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VAL    = 32'h1000_0001,
  parameter int unsigned NUM_USER_DR   = 2,
  parameter int unsigned USER_DR_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_b,
  input  logic                                   tms,
  input  logic                                   tdi,
  output logic                                   tdo,
  output logic                                   tdo_en,
  output logic [3:0]                             tap_state,
  output logic [IR_WIDTH-1:0]                    ir_value,
  input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_capture,
  output logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_update,
  output logic [NUM_USER_DR-1:0]                 user_update_stb
);

  localparam logic [IR_WIDTH-1:0] OP_IDCODE_L = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS_L = IR_WIDTH'(op_bypass(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(2'b01);

  tap_state_e w_state;
  logic w_next_tlr, w_cap_dr, w_shift_dr, w_upd_dr, w_cap_ir, w_shift_ir, w_upd_ir;

  jtag_tap_fsm u_fsm (
    .clk        (clk),
    .reset_b    (reset_b),
    .i_tms      (tms),
    .o_state    (w_state),
    .o_next_tlr (w_next_tlr),
    .o_cap_dr   (w_cap_dr),
    .o_shift_dr (w_shift_dr),
    .o_upd_dr   (w_upd_dr),
    .o_cap_ir   (w_cap_ir),
    .o_shift_ir (w_shift_ir),
    .o_upd_ir   (w_upd_ir)
  );

  logic [IR_WIDTH-1:0]                        r_ir_sr;
  logic [IR_WIDTH-1:0]                        r_ir_value;
  logic                                       r_bypass;
  logic [IDCODE_WIDTH-1:0]                    r_idcode_sr;
  logic [NUM_USER_DR-1:0][USER_DR_WIDTH-1:0]  r_user_sr;
  logic [NUM_USER_DR-1:0][USER_DR_WIDTH-1:0]  r_user_upd;
  logic                                       r_tdo;
  logic                                       r_tdo_en;

  logic                   w_sel_idcode;
  logic                   w_sel_bypass;
  logic [NUM_USER_DR-1:0] w_sel_user;
  logic                   w_dr_lsb;
  logic [NUM_USER_DR-1:0] w_stb;

  // Opcode decode; all-ones is excluded from user matches so it always
  // means BYPASS even when IR_WIDTH is small enough to alias a user opcode.
  always_comb begin
    w_sel_idcode = (r_ir_value == OP_IDCODE_L);
    for (int unsigned i = 0; i < NUM_USER_DR; i++) begin
      w_sel_user[i] = (32'(r_ir_value) == op_user(i)) && (r_ir_value != OP_BYPASS_L);
    end
    w_sel_bypass = !w_sel_idcode && (w_sel_user == '0);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_ir_sr    <= '0;
      r_ir_value <= OP_IDCODE_L;
    end else begin
      if (w_cap_ir)        r_ir_sr <= IR_CAPTURE;
      else if (w_shift_ir) r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
      if (w_next_tlr)      r_ir_value <= OP_IDCODE_L;
      else if (w_upd_ir)   r_ir_value <= r_ir_sr;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_bypass    <= 1'b0;
      r_idcode_sr <= '0;
    end else begin
      if (w_sel_bypass) begin
        if (w_cap_dr)        r_bypass <= 1'b0;
        else if (w_shift_dr) r_bypass <= tdi;
      end
      if (w_sel_idcode) begin
        if (w_cap_dr)        r_idcode_sr <= IDCODE_VAL;
        else if (w_shift_dr) r_idcode_sr <= {tdi, r_idcode_sr[IDCODE_WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_user_sr  <= '0;
      r_user_upd <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_USER_DR; i++) begin
        if (w_sel_user[i]) begin
          if (w_cap_dr)
            r_user_sr[i] <= user_capture[i*USER_DR_WIDTH +: USER_DR_WIDTH];
          else if (w_shift_dr)
            r_user_sr[i] <= {tdi, r_user_sr[i][USER_DR_WIDTH-1:1]};
        end
        if (w_next_tlr)
          r_user_upd[i] <= '0;
        else if (w_upd_dr && w_sel_user[i])
          r_user_upd[i] <= r_user_sr[i];
      end
    end
  end

  always_comb begin
    w_dr_lsb = r_bypass;
    if (w_sel_idcode) w_dr_lsb = r_idcode_sr[0];
    for (int unsigned i = 0; i < NUM_USER_DR; i++) begin
      if (w_sel_user[i]) w_dr_lsb = r_user_sr[i][0];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_USER_DR; i++) begin
      w_stb[i] = w_upd_dr && w_sel_user[i];
    end
  end

  always_ff @(negedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo_en <= w_shift_ir || w_shift_dr;
      if (w_shift_ir)      r_tdo <= r_ir_sr[0];
      else if (w_shift_dr) r_tdo <= w_dr_lsb;
    end
  end

  assign tdo             = r_tdo;
  assign tdo_en          = r_tdo_en;
  assign tap_state       = w_state;
  assign ir_value        = r_ir_value;
  assign user_update     = r_user_upd;
  assign user_update_stb = w_stb;

endmodule
